// File: rtl/intr_arb_pkg.sv
// Shared types and helpers for the round-robin interrupt vector arbiter.
package intr_arb_pkg;

   localparam int unsigned MAX_SRC = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PEND    = 2'd1,
      SERVICE = 2'd2
   } arb_state_t;

   // Vector table entry address for a given source index (32-bit wrap accepted).
   function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                            input logic [31:0] sel,
                                            input int unsigned shift);
      return base + (sel << shift);
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first eligible source at or after rr_ptr, wrapping.
module rr_priority_pick
   import intr_arb_pkg::*;
#(
   parameter int unsigned NUM_SRC = 8,
   parameter int unsigned VEC_W   = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] eligible,
   input  logic [VEC_W-1:0]   rr_ptr,
   output logic [VEC_W-1:0]   winner_c,
   output logic               any_valid_c
);

   // Scan from rr_ptr upward; the first hit wins.
   always_comb begin
      int unsigned idx;
      idx         = 0;
      winner_c    = '0;
      any_valid_c = 1'b0;
      for (int unsigned k = 0; k < MAX_SRC; k++) begin
         idx = (32'(rr_ptr) + k) % NUM_SRC;
         if ((k < NUM_SRC) && !any_valid_c && eligible[VEC_W'(idx)]) begin
            any_valid_c = 1'b1;
            winner_c    = VEC_W'(idx);
         end
      end
   end

endmodule

// File: rtl/intr_vector_arbiter.sv
// Round-robin interrupt arbiter with CPU ack / EOI sequencing.
// Optional feature macro: INTR_ARB_MASK_EN (adds irq_mask input).
module intr_vector_arbiter
   import intr_arb_pkg::*;
#(
   parameter int unsigned NUM_SRC   = 8,
   parameter int unsigned VEC_W     = $clog2(NUM_SRC),
   parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
   parameter int unsigned VEC_SHIFT = 2
) (
   input  logic               iccad_clk,
   input  logic               iccad_rst_n,
   input  logic [NUM_SRC-1:0] irq_req,
`ifdef INTR_ARB_MASK_EN
   input  logic [NUM_SRC-1:0] irq_mask,
`endif
   input  logic               cpu_ack,
   input  logic               cpu_eoi,
   output logic               o_irq_valid,
   output logic [VEC_W-1:0]   o_interrupt_vector_sel,
   output logic [31:0]        o_imm32,
   output logic [NUM_SRC-1:0] irq_grant,
   output logic               o_busy
);

   arb_state_t         state_q, state_nxt;
   logic [VEC_W-1:0]   rr_ptr_q, rr_ptr_nxt;
   logic [VEC_W-1:0]   sel_q, sel_nxt;
   logic [31:0]        imm_q, imm_nxt;
   logic               valid_q, valid_nxt;
   logic [NUM_SRC-1:0] grant_q, grant_nxt;
   logic               busy_q, busy_nxt;

   logic [NUM_SRC-1:0] eligible;
   logic [VEC_W-1:0]   winner_c;
   logic               any_valid_c;

   // Requests that may compete; only consulted in IDLE.
`ifdef INTR_ARB_MASK_EN
   assign eligible = irq_req & ~irq_mask;
`else
   assign eligible = irq_req;
`endif

   rr_priority_pick #(
      .NUM_SRC (NUM_SRC),
      .VEC_W   (VEC_W)
   ) u_pick (
      .eligible    (eligible),
      .rr_ptr      (rr_ptr_q),
      .winner_c    (winner_c),
      .any_valid_c (any_valid_c)
   );

   // State and registered outputs.
   always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
      if (!iccad_rst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         sel_q    <= '0;
         imm_q    <= '0;
         valid_q  <= 1'b0;
         grant_q  <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         rr_ptr_q <= rr_ptr_nxt;
         sel_q    <= sel_nxt;
         imm_q    <= imm_nxt;
         valid_q  <= valid_nxt;
         grant_q  <= grant_nxt;
         busy_q   <= busy_nxt;
      end
   end

   // Next state and next output values; grant is a single-cycle pulse on ack.
   always_comb begin
      state_nxt  = state_q;
      rr_ptr_nxt = rr_ptr_q;
      sel_nxt    = sel_q;
      imm_nxt    = imm_q;
      valid_nxt  = 1'b0;
      grant_nxt  = '0;

      case (state_q)
         IDLE: begin
            sel_nxt = '0;
            imm_nxt = '0;
            if (any_valid_c) begin
               state_nxt = PEND;
               sel_nxt   = winner_c;
               imm_nxt   = vec_addr(VEC_BASE, 32'(winner_c), VEC_SHIFT);
               valid_nxt = 1'b1;
            end
         end
         PEND: begin
            valid_nxt = 1'b1;
            if (cpu_ack) begin
               state_nxt  = SERVICE;
               valid_nxt  = 1'b0;
               grant_nxt  = NUM_SRC'(1) << sel_q;
               rr_ptr_nxt = (sel_q == VEC_W'(NUM_SRC - 1)) ? '0 : sel_q + VEC_W'(1);
            end
         end
         SERVICE: begin
            if (cpu_eoi) begin
               state_nxt = IDLE;
               sel_nxt   = '0;
               imm_nxt   = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            sel_nxt   = '0;
            imm_nxt   = '0;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   assign o_irq_valid            = valid_q;
   assign o_interrupt_vector_sel = sel_q;
   assign o_imm32                = imm_q;
   assign irq_grant              = grant_q;
   assign o_busy                 = busy_q;

endmodule

// File: tb/tb_intr_vector_arbiter.sv
// Directed self-checking bench for intr_vector_arbiter (NUM_SRC = 8).
module tb_intr_vector_arbiter;

   logic       iccad_clk;
   logic       iccad_rst_n;
   logic [7:0] irq_req;
`ifdef INTR_ARB_MASK_EN
   logic [7:0] irq_mask;
`endif
   logic       cpu_ack;
   logic       cpu_eoi;
   logic       o_irq_valid;
   logic [2:0] o_interrupt_vector_sel;
   logic [31:0] o_imm32;
   logic [7:0] irq_grant;
   logic       o_busy;

   int n_checks = 0;
   int n_fail   = 0;

   intr_vector_arbiter u_dut (
      .iccad_clk              (iccad_clk),
      .iccad_rst_n            (iccad_rst_n),
      .irq_req                (irq_req),
`ifdef INTR_ARB_MASK_EN
      .irq_mask               (irq_mask),
`endif
      .cpu_ack                (cpu_ack),
      .cpu_eoi                (cpu_eoi),
      .o_irq_valid            (o_irq_valid),
      .o_interrupt_vector_sel (o_interrupt_vector_sel),
      .o_imm32                (o_imm32),
      .irq_grant              (irq_grant),
      .o_busy                 (o_busy)
   );

   initial iccad_clk = 1'b0;
   always #5 iccad_clk = ~iccad_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(negedge iccad_clk);
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".valid"}, 32'(o_irq_valid), 32'd0);
      check({tag, ".busy"},  32'(o_busy), 32'd0);
      check({tag, ".sel"},   32'(o_interrupt_vector_sel), 32'd0);
      check({tag, ".imm"},   o_imm32, 32'd0);
      check({tag, ".grant"}, 32'(irq_grant), 32'd0);
   endtask

   // Full request -> ack -> eoi round trip with expected winner.
   task automatic serve(input string tag, input logic [7:0] req, input int unsigned exp_sel);
      logic [7:0] g;
      g = 8'd1 << exp_sel;
      irq_req = req;
      tick();
      check({tag, ".valid"}, 32'(o_irq_valid), 32'd1);
      check({tag, ".sel"},   32'(o_interrupt_vector_sel), 32'(exp_sel));
      check({tag, ".imm"},   o_imm32, 32'h100 + 32'(exp_sel * 4));
      cpu_ack = 1'b1;
      tick();
      cpu_ack = 1'b0;
      check({tag, ".grant"}, 32'(irq_grant), 32'(g));
      check({tag, ".svc_busy"}, 32'(o_busy), 32'd1);
      cpu_eoi = 1'b1;
      tick();
      cpu_eoi = 1'b0;
      check({tag, ".grant_off"}, 32'(irq_grant), 32'd0);
      check({tag, ".done_busy"}, 32'(o_busy), 32'd0);
   endtask

   initial begin
      iccad_rst_n = 1'b0;
      irq_req     = '0;
      cpu_ack     = 1'b0;
      cpu_eoi     = 1'b0;
`ifdef INTR_ARB_MASK_EN
      irq_mask    = '0;
`endif
      tick();
      check_idle("rst");
      iccad_rst_n = 1'b1;

      // Idle with no request, stray ack/eoi ignored.
      cpu_ack = 1'b1;
      cpu_eoi = 1'b1;
      tick();
      tick();
      cpu_ack = 1'b0;
      cpu_eoi = 1'b0;
      check_idle("noreq");

      // Single request from source 5; rr_ptr then 6.
      serve("single", 8'h20, 5);
      irq_req = '0;

      // Pend source 2 (search 6,7,0,1,2), then reset mid-PEND.
      irq_req = 8'h04;
      tick();
      check("prerst.sel", 32'(o_interrupt_vector_sel), 32'd2);
      irq_req = '0;
      iccad_rst_n = 1'b0;
      #1;
      check_idle("midrst");
      tick();
      check_idle("midrst_hold");
      iccad_rst_n = 1'b1;

      // rr_ptr back to 0: 8'h81 picks 0, then alternates 7,0,7.
      serve("rr0", 8'h81, 0);
      serve("rr1", 8'h81, 7);
      serve("rr2", 8'h81, 0);
      serve("rr3", 8'h81, 7);
      // Source 7 served -> rr_ptr wraps to 0.
      serve("wrap", 8'hFF, 0);
      // rr_ptr = 1 now.
      serve("rr_ptr1", 8'h03, 1);
      irq_req = '0;
      tick();
      check_idle("gap");

      // rr_ptr = 2: source 4 wins; boundary conditions in PEND.
      irq_req = 8'h10;
      tick();
      check("pend.sel", 32'(o_interrupt_vector_sel), 32'd4);
      check("pend.imm", o_imm32, 32'h110);
      irq_req = 8'h08;
      cpu_eoi = 1'b1;
      tick();
      cpu_eoi = 1'b0;
      check("eoi_in_pend.valid", 32'(o_irq_valid), 32'd1);
      check("newreq_in_pend.sel", 32'(o_interrupt_vector_sel), 32'd4);
      irq_req = '0;
      tick();
      check("drop_in_pend.valid", 32'(o_irq_valid), 32'd1);
      check("drop_in_pend.sel", 32'(o_interrupt_vector_sel), 32'd4);
      cpu_ack = 1'b1;
      cpu_eoi = 1'b1;
      tick();
      cpu_ack = 1'b0;
      cpu_eoi = 1'b0;
      check("ackeoi.grant", 32'(irq_grant), 32'h10);
      check("ackeoi.busy", 32'(o_busy), 32'd1);
      check("ackeoi.valid", 32'(o_irq_valid), 32'd0);
      irq_req = 8'h01;
      tick();
      check("svc_wait.busy", 32'(o_busy), 32'd1);
      check("svc_wait.grant", 32'(irq_grant), 32'd0);
      check("svc_wait.sel", 32'(o_interrupt_vector_sel), 32'd4);
      irq_req = '0;
      cpu_eoi = 1'b1;
      tick();
      cpu_eoi = 1'b0;
      check_idle("ackeoi_done");

`ifdef INTR_ARB_MASK_EN
      // rr_ptr = 5: source 0 masked, so source 1 wins; later mask change ignored.
      irq_mask = 8'h01;
      irq_req  = 8'h03;
      tick();
      check("mask.sel", 32'(o_interrupt_vector_sel), 32'd1);
      check("mask.imm", o_imm32, 32'h104);
      irq_mask = 8'h02;
      tick();
      check("mask_chg.sel", 32'(o_interrupt_vector_sel), 32'd1);
      check("mask_chg.valid", 32'(o_irq_valid), 32'd1);
      cpu_ack = 1'b1;
      tick();
      cpu_ack = 1'b0;
      check("mask.grant", 32'(irq_grant), 32'h02);
      irq_req  = '0;
      irq_mask = '0;
      cpu_eoi  = 1'b1;
      tick();
      cpu_eoi  = 1'b0;
      check_idle("mask_done");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
